// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - client request/response bundle for the register-file port arbiter
interface regfile_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              ack;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Client side: issues ops, receives completion and read data
    modport master (
        output req, we, ra1, ra2, wa, wd,
        input  ack, rd1, rd2
    );

    // Arbiter side
    modport slave (
        input  req, we, ra1, ra2, wa, wd,
        output ack, rd1, rd2
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - two-client serialising arbiter in front of a 2R/1W register file
module regfile_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    regfile_port_arbiter_if.slave c0,
    regfile_port_arbiter_if.slave c1,
    output logic [ADDR_W-1:0]   rf_A1,
    output logic [ADDR_W-1:0]   rf_A2,
    output logic [ADDR_W-1:0]   rf_A3,
    output logic [DATA_W-1:0]   rf_WD3,
    output logic                rf_WE3,
    input  logic [DATA_W-1:0]   rf_RD1,
    input  logic [DATA_W-1:0]   rf_RD2,
    output logic                busy
);

    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] ra2_q, ra2_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] c0_rd1_q, c0_rd1_d;
    logic [DATA_W-1:0] c0_rd2_q, c0_rd2_d;
    logic [DATA_W-1:0] c1_rd1_q, c1_rd1_d;
    logic [DATA_W-1:0] c1_rd2_q, c1_rd2_d;

    logic              is_exec;
    logic              write_dropped;
    logic [DATA_W-1:0] rd1_masked;
    logic [DATA_W-1:0] rd2_masked;

    assign is_exec       = (state_q == ST_EXEC);
    assign write_dropped = ZR && (wa_q == '0);
    assign rd1_masked    = (ZR && (ra1_q == '0)) ? '0 : rf_RD1;
    assign rd2_masked    = (ZR && (ra2_q == '0)) ? '0 : rf_RD2;

    // Register-file pins are only driven during EXEC; reset blocks an in-flight write
    always_comb begin
        rf_A1  = '0;
        rf_A2  = '0;
        rf_A3  = '0;
        rf_WD3 = '0;
        rf_WE3 = 1'b0;
        if (is_exec) begin
            if (we_q) begin
                rf_A3  = wa_q;
                rf_WD3 = wd_q;
                rf_WE3 = !write_dropped && !reset;
            end else begin
                rf_A1 = ra1_q;
                rf_A2 = ra2_q;
            end
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign c0.ack = (state_q == ST_ACK) && !win_q;
    assign c1.ack = (state_q == ST_ACK) &&  win_q;
    assign c0.rd1 = c0_rd1_q;
    assign c0.rd2 = c0_rd2_q;
    assign c1.rd1 = c1_rd1_q;
    assign c1.rd2 = c1_rd2_q;

    // Next-state: grant and latch in IDLE, capture read data in CAPT
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        ra1_d        = ra1_q;
        ra2_d        = ra2_q;
        wa_d         = wa_q;
        wd_d         = wd_q;
        c0_rd1_d     = c0_rd1_q;
        c0_rd2_d     = c0_rd2_q;
        c1_rd1_d     = c1_rd1_q;
        c1_rd2_d     = c1_rd2_q;
        unique case (state_q)
            ST_IDLE: begin
                if (c0.req || c1.req) begin
                    // Contention goes to whoever was not served last
                    if (c0.req && c1.req) begin
                        win_d = ~last_grant_q;
                    end else begin
                        win_d = c1.req;
                    end
                    last_grant_d = win_d;
                    if (win_d) begin
                        we_d  = c1.we;
                        ra1_d = c1.ra1;
                        ra2_d = c1.ra2;
                        wa_d  = c1.wa;
                        wd_d  = c1.wd;
                    end else begin
                        we_d  = c0.we;
                        ra1_d = c0.ra1;
                        ra2_d = c0.ra2;
                        wa_d  = c0.wa;
                        wd_d  = c0.wd;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                if (!we_q) begin
                    if (win_q) begin
                        c1_rd1_d = rd1_masked;
                        c1_rd2_d = rd2_masked;
                    end else begin
                        c0_rd1_d = rd1_masked;
                        c0_rd2_d = rd2_masked;
                    end
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-op registers; reset abandons any op without an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            ra1_q        <= '0;
            ra2_q        <= '0;
            wa_q         <= '0;
            wd_q         <= '0;
            c0_rd1_q     <= '0;
            c0_rd2_q     <= '0;
            c1_rd1_q     <= '0;
            c1_rd2_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            ra1_q        <= ra1_d;
            ra2_q        <= ra2_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            c0_rd1_q     <= c0_rd1_d;
            c0_rd2_q     <= c0_rd2_d;
            c1_rd1_q     <= c1_rd1_d;
            c1_rd2_q     <= c1_rd2_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed-vector bench for regfile_port_arbiter
module tb_regfile_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) c0_if ();
    regfile_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) c1_if ();

    logic [AW-1:0] rf_A1, rf_A2, rf_A3;
    logic [DW-1:0] rf_WD3, rf_RD1, rf_RD2;
    logic          rf_WE3, busy;

    regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .c0     (c0_if),
        .c1     (c1_if),
        .rf_A1  (rf_A1),
        .rf_A2  (rf_A2),
        .rf_A3  (rf_A3),
        .rf_WD3 (rf_WD3),
        .rf_WE3 (rf_WE3),
        .rf_RD1 (rf_RD1),
        .rf_RD2 (rf_RD2),
        .busy   (busy)
    );

    // Register file stand-in: registered reads that only update when not writing
    logic [DW-1:0] mem [32];
    logic          loaded = 1'b0;
    int            we_count = 0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A50000 | i;
            loaded <= 1'b1;
        end else if (rf_WE3) begin
            mem[rf_A3] <= rf_WD3;
        end
        if (!rf_WE3) begin
            rf_RD1 <= mem[rf_A1];
            rf_RD2 <= mem[rf_A2];
        end
        if (rf_WE3) we_count <= we_count + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic req, input logic we,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (id == 0) begin
            c0_if.req = req; c0_if.we = we; c0_if.ra1 = ra1;
            c0_if.ra2 = ra2; c0_if.wa = wa; c0_if.wd = wd;
        end else begin
            c1_if.req = req; c1_if.we = we; c1_if.ra1 = ra1;
            c1_if.ra2 = ra2; c1_if.wa = wa; c1_if.wd = wd;
        end
    endtask

    function automatic logic get_ack(input int id);
        return (id == 0) ? c0_if.ack : c1_if.ack;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One op on one client; returns ticks from request to ack and the read data seen with ack
    task automatic run_op(input int id, input logic we, input logic [AW-1:0] ra1,
                          input logic [AW-1:0] ra2, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, output int lat,
                          output logic [DW-1:0] rd1, output logic [DW-1:0] rd2);
        lat = -1;
        rd1 = '0;
        rd2 = '0;
        drive(id, 1, we, ra1, ra2, wa, wd);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (get_ack(id)) begin
                lat = t;
                rd1 = (id == 0) ? c0_if.rd1 : c1_if.rd1;
                rd2 = (id == 0) ? c0_if.rd2 : c1_if.rd2;
                break;
            end
        end
        tick();
        drive(id, 0, 0, 0, 0, 0, 0);
    endtask

    // Both clients request reads in the same cycle; returns the ack tick of each
    task automatic run_pair(output int t0, output int t1);
        logic d0, d1;
        t0 = -1; t1 = -1; d0 = 1'b0; d1 = 1'b0;
        drive(0, 1, 0, 5'd1, 5'd2, 0, 0);
        drive(1, 1, 0, 5'd3, 5'd4, 0, 0);
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (d0) begin drive(0, 0, 0, 0, 0, 0, 0); d0 = 1'b0; end
            if (d1) begin drive(1, 0, 0, 0, 0, 0, 0); d1 = 1'b0; end
            if (c0_if.ack) begin t0 = t; d0 = 1'b1; end
            if (c1_if.ack) begin t1 = t; d1 = 1'b1; end
            if (t0 >= 0 && t1 >= 0 && !d0 && !d1) break;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, t0, t1, wc, order[$];
        logic [DW-1:0] rd1, rd2;
        logic seen_ack;

        do_reset();
        check_eq("reset_busy", busy, 0);
        check_eq("reset_c0_ack", c0_if.ack, 0);
        check_eq("reset_c1_ack", c1_if.ack, 0);
        check_eq("reset_we3", rf_WE3, 0);
        check_eq("reset_a1", rf_A1, 0);
        check_eq("reset_c0_rd1", c0_if.rd1, 0);

        wc = we_count;
        run_op(0, 1, 0, 0, 5'd5, 32'hDEADBEEF, lat, rd1, rd2);
        check_eq("wr_r5_lat", lat, 3);
        check_eq("wr_r5_mem", mem[5], 32'hDEADBEEF);
        check_eq("wr_r5_we_pulses", we_count - wc, 1);
        run_op(0, 0, 5'd5, 5'd0, 0, 0, lat, rd1, rd2);
        check_eq("rd_r5_lat", lat, 3);
        check_eq("rd_r5_rd1", rd1, 32'hDEADBEEF);
        check_eq("rd_r0_rd2", rd2, 0);

        do_reset();
        run_pair(t0, t1);
        check_eq("pair1_c0_ack", t0, 3);
        check_eq("pair1_c1_ack", t1, 7);
        check_eq("pair1_c0_rd1", c0_if.rd1, 32'hA5A50001);
        check_eq("pair1_c1_rd2", c1_if.rd2, 32'hA5A50004);
        run_pair(t0, t1);
        check_eq("pair2_c0_ack", t0, 3);
        check_eq("pair2_c1_ack", t1, 7);
        run_op(0, 0, 5'd1, 5'd1, 0, 0, lat, rd1, rd2);
        run_pair(t0, t1);
        check_eq("pair3_c1_ack", t1, 3);
        check_eq("pair3_c0_ack", t0, 7);

        wc = we_count;
        run_op(1, 1, 0, 0, 5'd0, 32'h1234, lat, rd1, rd2);
        check_eq("wr_r0_lat", lat, 3);
        check_eq("wr_r0_no_we", we_count - wc, 0);
        run_op(1, 0, 5'd0, 5'd5, 0, 0, lat, rd1, rd2);
        check_eq("rd_r0_rd1", rd1, 0);
        check_eq("rd_r5_c1_rd2", rd2, 32'hDEADBEEF);

        do_reset();
        drive(0, 1, 0, 5'd1, 5'd2, 0, 0);
        drive(1, 1, 0, 5'd3, 5'd4, 0, 0);
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (c0_if.ack && c1_if.ack) check_eq("alt_double_ack", 1, 0);
            if (c0_if.ack) order.push_back(0);
            if (c1_if.ack) order.push_back(1);
            if (order.size() >= 8) break;
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check_eq("alt_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++) check_eq($sformatf("alt_grant%0d", i), order[i], i % 2);
        check_eq("alt_idle_busy", busy, 0);

        drive(0, 1, 1, 0, 0, 5'd7, 32'h55);
        tick();
        check_eq("midrst_exec_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_we3_held", rf_WE3, 0);
        tick();
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ack", c0_if.ack, 0);
        check_eq("midrst_a3", rf_A3, 0);
        check_eq("midrst_wd3", rf_WD3, 0);
        check_eq("midrst_c0_rd1", c0_if.rd1, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        seen_ack = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (c0_if.ack || c1_if.ack) seen_ack = 1'b1;
        end
        check_eq("midrst_no_ack", seen_ack, 0);
        check_eq("midrst_r7", mem[7], 32'hA5A50007);

        drive(0, 1, 1, 0, 0, 5'd3, 32'hA);
        drive(1, 1, 0, 5'd3, 5'd3, 0, 0);
        t0 = -1; t1 = -1; rd1 = '0; rd2 = '0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == t0 + 1 && t0 > 0) drive(0, 0, 0, 0, 0, 0, 0);
            if (t == 5) drive(1, 1, 1, 5'd0, 5'd0, 5'd3, 32'hFFFF);
            if (c0_if.ack) t0 = t;
            if (c1_if.ack) begin
                t1 = t;
                rd1 = c1_if.rd1;
                rd2 = c1_if.rd2;
                break;
            end
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check_eq("b2b_c0_ack", t0, 3);
        check_eq("b2b_c1_ack", t1, 7);
        check_eq("b2b_c1_rd1", rd1, 32'hA);
        check_eq("b2b_c1_rd2", rd2, 32'hA);
        check_eq("b2b_r3", mem[3], 32'hA);
        check_eq("b2b_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
